// File: rtl/branch_pc_unit_pkg.sv
// Shared encodings for the branch/PC unit.
// Branch funct3 codes, base opcodes and PC-control FSM states.
package branch_pc_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/comparator inputs and PC/status outputs of the branch unit.
// master drives the instruction side, slave is the branch unit.
interface branch_pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             instr_valid;
    logic             imem_ready;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_data;
    logic             rs2_msb;
    logic             BrEq;
    logic             BrLt;
    logic             trap_ack;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             pc_sel;
    logic             taken;
    logic             illegal_br;
    logic             trap;
    logic [XLEN-1:0]  mepc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output instr_valid, imem_ready, is_branch, is_jal, is_jalr,
        output funct3, imm, rs1_data, rs2_msb, BrEq, BrLt, trap_ack,
        input  pc, pc_plus4, pc_sel, taken, illegal_br, trap, mepc,
        input  br_cnt, taken_cnt
    );

    modport slave (
        input  instr_valid, imem_ready, is_branch, is_jal, is_jalr,
        input  funct3, imm, rs1_data, rs2_msb, BrEq, BrLt, trap_ack,
        output pc, pc_plus4, pc_sel, taken, illegal_br, trap, mepc,
        output br_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Conditional-branch outcome from funct3 and comparator flags.
// Signed less-than is rebuilt from the operand MSBs and unsigned BrLt.
module branch_cond_eval
    import branch_pc_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    input  logic       rs1_msb,
    input  logic       rs2_msb,
    output logic       taken,
    output logic       illegal
);

    logic slt;

    assign slt = (rs1_msb != rs2_msb) ? rs1_msb : br_lt;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (funct3)
            F3_BEQ:  taken = br_eq;
            F3_BNE:  taken = !br_eq;
            F3_BLT:  taken = slt;
            F3_BGE:  taken = !slt;
            F3_BLTU: taken = br_lt;
            F3_BGEU: taken = !br_lt;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch/jump resolution, PC register, stall hold, misalign trap
// and saturating retired-branch counters.
module branch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100),
    parameter int              CNT_W    = 32
) (
    input logic              clk,
    input logic              rst,
    branch_pc_unit_if.slave  bus
);
    import branch_pc_unit_pkg::*;

    state_t st_q, st_n;

    logic [XLEN-1:0]  pc_q, pc_n, mepc_q;
    logic [XLEN-1:0]  pc_plus4, pc_imm, jalr_tgt;
    logic [XLEN-1:0]  dec_tgt, run_next;
    logic [CNT_W-1:0] br_q, tk_q;
    logic             trap_q;
    logic             cond_tk, cond_ill;
    logic             dec_take, dec_cond, misalign;
    logic             pc_we, retire, ret_cond, ret_tk;
    logic             hold_we, trap_set, trap_clr;
    logic             sel, tk;

    logic [XLEN-1:0]  h_next;
    logic             h_sel, h_cond, h_tk;

    branch_cond_eval u_cond (
        .funct3  (bus.funct3),
        .br_eq   (bus.BrEq),
        .br_lt   (bus.BrLt),
        .rs1_msb (bus.rs1_data[XLEN-1]),
        .rs2_msb (bus.rs2_msb),
        .taken   (cond_tk),
        .illegal (cond_ill)
    );

    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc_imm   = pc_q + bus.imm;
    assign jalr_tgt = (bus.rs1_data + bus.imm) & ~XLEN'(1);

    // Overlapping flags are legal: jalr beats jal beats branch.
    always_comb begin
        dec_take = 1'b0;
        dec_cond = 1'b0;
        dec_tgt  = pc_plus4;
        priority case (1'b1)
            bus.is_jalr: begin
                dec_take = 1'b1;
                dec_tgt  = jalr_tgt;
            end
            bus.is_jal: begin
                dec_take = 1'b1;
                dec_tgt  = pc_imm;
            end
            bus.is_branch: begin
                dec_cond = 1'b1;
                dec_take = cond_tk;
                dec_tgt  = pc_imm;
            end
            default: ;
        endcase
    end

    assign misalign = dec_take && (dec_tgt[1:0] != 2'b00);
    assign run_next = dec_take ? dec_tgt : pc_plus4;

    always_comb begin
        st_n     = st_q;
        pc_n     = pc_q;
        pc_we    = 1'b0;
        retire   = 1'b0;
        ret_cond = 1'b0;
        ret_tk   = 1'b0;
        hold_we  = 1'b0;
        trap_set = 1'b0;
        trap_clr = 1'b0;
        sel      = 1'b0;
        tk       = 1'b0;
        unique case (st_q)
            ST_RUN: begin
                sel = bus.instr_valid && dec_take;
                tk  = bus.instr_valid && dec_take;
                if (bus.instr_valid) begin
                    if (misalign) begin
                        trap_set = 1'b1;
                        st_n     = ST_TRAP;
                    end else if (bus.imem_ready) begin
                        pc_we    = 1'b1;
                        pc_n     = run_next;
                        retire   = 1'b1;
                        ret_cond = dec_cond;
                        ret_tk   = dec_take;
                    end else begin
                        hold_we = 1'b1;
                        st_n    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                sel = h_sel;
                tk  = h_tk;
                if (bus.imem_ready) begin
                    pc_we    = 1'b1;
                    pc_n     = h_next;
                    retire   = 1'b1;
                    ret_cond = h_cond;
                    ret_tk   = h_tk;
                    st_n     = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (bus.trap_ack) begin
                    pc_we    = 1'b1;
                    pc_n     = TRAP_VEC;
                    trap_clr = 1'b1;
                    st_n     = ST_RUN;
                end
            end
            default: st_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_RUN;
            pc_q   <= RESET_PC;
            mepc_q <= '0;
            trap_q <= 1'b0;
            br_q   <= '0;
            tk_q   <= '0;
            h_next <= '0;
            h_sel  <= 1'b0;
            h_cond <= 1'b0;
            h_tk   <= 1'b0;
        end else begin
            st_q <= st_n;
            if (pc_we) pc_q <= pc_n;
            if (trap_set) begin
                mepc_q <= pc_q;
                trap_q <= 1'b1;
            end else if (trap_clr) begin
                trap_q <= 1'b0;
            end
            if (hold_we) begin
                h_next <= run_next;
                h_sel  <= dec_take;
                h_cond <= dec_cond;
                h_tk   <= dec_take;
            end
            if (retire && ret_cond && (br_q != {CNT_W{1'b1}}))
                br_q <= br_q + CNT_W'(1);
            if (retire && ret_cond && ret_tk && (tk_q != {CNT_W{1'b1}}))
                tk_q <= tk_q + CNT_W'(1);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.pc_sel     = sel;
    assign bus.taken      = tk;
    assign bus.illegal_br = bus.is_branch && cond_ill;
    assign bus.trap       = trap_q;
    assign bus.mepc       = mepc_q;
    assign bus.br_cnt     = br_q;
    assign bus.taken_cnt  = tk_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scenario bench for branch_pc_unit with a PC/counter scoreboard.
// Narrow counters let saturation be reached in a few branches.
module tb_branch_pc_unit;

    logic clk;
    logic rst;

    branch_pc_unit_if #(.XLEN(32), .CNT_W(4)) bif ();

    branch_pc_unit #(
        .XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  br;
        logic [3:0]  tk;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          nchk  = 0;
    int          npass = 0;
    logic [31:0] m_pc;
    logic [3:0]  m_br, m_tk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input bit rdy, input bit br,
                       input bit jal, input bit jalr,
                       input logic [2:0] f3, input logic [31:0] imm,
                       input logic [31:0] rs1, input bit r2m,
                       input bit eq, input bit lt);
        bif.instr_valid = v;
        bif.imem_ready  = rdy;
        bif.is_branch   = br;
        bif.is_jal      = jal;
        bif.is_jalr     = jalr;
        bif.funct3      = f3;
        bif.imm         = imm;
        bif.rs1_data    = rs1;
        bif.rs2_msb     = r2m;
        bif.BrEq        = eq;
        bif.BrLt        = lt;
        bif.trap_ack    = 1'b0;
        #1;
    endtask

    // Reference model: one retirement, saturating 4-bit counters.
    task automatic m_push(input bit cond, input bit tk, input logic [31:0] nxt);
        m_pc = nxt;
        if (cond && m_br != 4'hF) m_br = m_br + 4'd1;
        if (cond && tk && m_tk != 4'hF) m_tk = m_tk + 4'd1;
        sb.push_back('{m_pc, m_br, m_tk});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        tick();
        nchk++;
        if (bif.pc !== 32'h0 || bif.trap !== 1'b0 || bif.mepc !== 32'h0)
            $display("FAIL reset_pc: pc=%h trap=%b mepc=%h, want 0/0/0",
                     bif.pc, bif.trap, bif.mepc);
        else npass++;
        nchk++;
        if (bif.br_cnt !== 4'd0 || bif.taken_cnt !== 4'd0)
            $display("FAIL reset_cnt: br=%0d tk=%0d, want 0/0",
                     bif.br_cnt, bif.taken_cnt);
        else npass++;
        rst = 1'b0;
        #1;
        nchk++;
        if (bif.pc_plus4 !== 32'h4)
            $display("FAIL reset_plus4: got %h want 4", bif.pc_plus4);
        else npass++;
        m_pc = 32'h0;
        m_br = 4'd0;
        m_tk = 4'd0;
        sb.delete();
    endtask

    task automatic test_beq();
        drv(1, 1, 0, 1, 0, 3'b000, 32'h40, 0, 0, 0, 0);
        m_push(0, 1, 32'h40);
        tick();
        e = sb.pop_front();
        nchk++;
        if (bif.pc !== e.pc) $display("FAIL jal_pc: got %h want %h", bif.pc, e.pc);
        else npass++;
        drv(1, 1, 1, 0, 0, 3'b000, 32'h10, 0, 0, 1, 0);
        nchk++;
        if (bif.taken !== 1'b1 || bif.pc_sel !== 1'b1 || bif.pc_plus4 !== 32'h44)
            $display("FAIL beq_comb: taken=%b sel=%b plus4=%h, want 1/1/44",
                     bif.taken, bif.pc_sel, bif.pc_plus4);
        else npass++;
        m_push(1, 1, 32'h50);
        tick();
        e = sb.pop_front();
        nchk++;
        if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
            $display("FAIL beq_retire: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                     bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
        else npass++;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        bit          r2m, eq, lt;
        logic [31:0] imm;
        bit          tk;
    } row_t;

    task automatic test_cond_table();
        row_t rows[6];
        rows[0] = '{3'b100, 32'h8000_0000, 0, 0, 0, 32'h20, 1};
        rows[1] = '{3'b110, 32'h8000_0000, 0, 0, 0, 32'h20, 0};
        rows[2] = '{3'b101, 32'h0000_0005, 1, 0, 1, 32'h08, 1};
        rows[3] = '{3'b001, 32'h0000_0000, 0, 1, 0, 32'h08, 0};
        rows[4] = '{3'b111, 32'h0000_0000, 0, 0, 0, 32'hFFFF_FFF0, 1};
        rows[5] = '{3'b100, 32'h0000_0010, 0, 0, 1, 32'h04, 1};
        for (int i = 0; i < 6; i++) begin
            drv(1, 1, 1, 0, 0, rows[i].f3, rows[i].imm, rows[i].rs1,
                rows[i].r2m, rows[i].eq, rows[i].lt);
            nchk++;
            if (bif.taken !== rows[i].tk || bif.illegal_br !== 1'b0)
                $display("FAIL cond_taken[%0d]: taken=%b ill=%b, want %b/0",
                         i, bif.taken, bif.illegal_br, rows[i].tk);
            else npass++;
            m_push(1, rows[i].tk, rows[i].tk ? m_pc + rows[i].imm : m_pc + 32'd4);
            tick();
            e = sb.pop_front();
            nchk++;
            if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
                $display("FAIL cond_retire[%0d]: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                         i, bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
            else npass++;
        end
    endtask

    task automatic test_jalr_trap();
        drv(1, 1, 1, 1, 1, 3'b000, 32'd3, 32'h1001, 0, 1, 0);
        m_push(0, 1, 32'h1004);
        tick();
        e = sb.pop_front();
        nchk++;
        if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
            $display("FAIL jalr_prio: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                     bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
        else npass++;
        drv(1, 1, 1, 1, 0, 3'b001, 32'h10, 0, 0, 1, 0);
        m_push(0, 1, 32'h1014);
        tick();
        e = sb.pop_front();
        nchk++;
        if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
            $display("FAIL jal_prio: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                     bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
        else npass++;
        drv(1, 1, 0, 0, 1, 3'b000, 32'd1, 32'h1001, 0, 0, 0);
        tick();
        nchk++;
        if (bif.trap !== 1'b1 || bif.mepc !== 32'h1014 || bif.pc !== 32'h1014
            || bif.br_cnt !== m_br || bif.taken_cnt !== m_tk)
            $display("FAIL jalr_trap: trap=%b mepc=%h pc=%h br=%0d, want 1/1014/1014/%0d",
                     bif.trap, bif.mepc, bif.pc, bif.br_cnt, m_br);
        else npass++;
        drv(1, 1, 0, 1, 0, 3'b000, 32'h10, 0, 0, 0, 0);
        nchk++;
        if (bif.taken !== 1'b0 || bif.pc_sel !== 1'b0)
            $display("FAIL trap_outputs: taken=%b sel=%b, want 0/0",
                     bif.taken, bif.pc_sel);
        else npass++;
        tick();
        nchk++;
        if (bif.pc !== 32'h1014 || bif.trap !== 1'b1)
            $display("FAIL trap_hold: pc=%h trap=%b, want 1014/1", bif.pc, bif.trap);
        else npass++;
        drv(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        bif.trap_ack = 1'b1;
        tick();
        nchk++;
        if (bif.pc !== 32'h100 || bif.trap !== 1'b0)
            $display("FAIL trap_ack: pc=%h trap=%b, want 100/0", bif.pc, bif.trap);
        else npass++;
        tick();
        nchk++;
        if (bif.pc !== 32'h100 || bif.trap !== 1'b0)
            $display("FAIL ack_in_run: pc=%h trap=%b, want 100/0", bif.pc, bif.trap);
        else npass++;
        bif.trap_ack = 1'b0;
        m_pc = 32'h100;
    endtask

    task automatic test_hold();
        drv(1, 0, 1, 0, 0, 3'b001, 32'h40, 0, 0, 0, 0);
        nchk++;
        if (bif.taken !== 1'b1)
            $display("FAIL bne_comb: taken=%b want 1", bif.taken);
        else npass++;
        tick();
        for (int i = 0; i < 2; i++) begin
            bif.BrEq = ~bif.BrEq;
            #1;
            nchk++;
            if (bif.taken !== 1'b1 || bif.pc_sel !== 1'b1 || bif.pc !== 32'h100
                || bif.br_cnt !== m_br)
                $display("FAIL hold[%0d]: taken=%b sel=%b pc=%h br=%0d, want 1/1/100/%0d",
                         i, bif.taken, bif.pc_sel, bif.pc, bif.br_cnt, m_br);
            else npass++;
            tick();
        end
        bif.BrEq = 1'b1;
        bif.imem_ready = 1'b1;
        #1;
        m_push(1, 1, 32'h140);
        tick();
        e = sb.pop_front();
        nchk++;
        if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
            $display("FAIL hold_release: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                     bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
        else npass++;
        drv(0, 1, 1, 0, 0, 3'b000, 32'h40, 0, 0, 1, 0);
        m_push(0, 0, m_pc);
        tick();
        e = sb.pop_front();
        nchk++;
        if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
            $display("FAIL no_valid: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                     bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
        else npass++;
    endtask

    task automatic test_illegal_sat();
        logic [2:0] f3;
        for (int i = 0; i < 2; i++) begin
            f3 = (i == 0) ? 3'b010 : 3'b011;
            drv(1, 1, 1, 0, 0, f3, 32'h10, 0, 0, 1, 1);
            nchk++;
            if (bif.illegal_br !== 1'b1 || bif.taken !== 1'b0)
                $display("FAIL illegal[%0d]: ill=%b taken=%b, want 1/0",
                         i, bif.illegal_br, bif.taken);
            else npass++;
            m_push(1, 0, m_pc + 32'd4);
            tick();
            e = sb.pop_front();
            nchk++;
            if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
                $display("FAIL illegal_retire[%0d]: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                         i, bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
            else npass++;
        end
        for (int i = 0; i < 12; i++) begin
            drv(1, 1, 1, 0, 0, 3'b000, 32'd4, 0, 0, 1, 0);
            m_push(1, 1, m_pc + 32'd4);
            tick();
            e = sb.pop_front();
            nchk++;
            if (bif.pc !== e.pc || bif.br_cnt !== e.br || bif.taken_cnt !== e.tk)
                $display("FAIL sat_step[%0d]: pc=%h br=%0d tk=%0d, want %h/%0d/%0d",
                         i, bif.pc, bif.br_cnt, bif.taken_cnt, e.pc, e.br, e.tk);
            else npass++;
        end
        drv(1, 1, 1, 0, 0, 3'b010, 32'h10, 0, 0, 1, 0);
        tick();
        nchk++;
        if (bif.br_cnt !== 4'hF || bif.taken_cnt !== 4'hF)
            $display("FAIL sat_hold: br=%0d tk=%0d, want 15/15",
                     bif.br_cnt, bif.taken_cnt);
        else npass++;
    endtask

    task automatic test_reset_states();
        drv(1, 0, 1, 0, 0, 3'b000, 32'h20, 0, 0, 1, 0);
        tick();
        rst = 1'b1;
        tick();
        nchk++;
        if (bif.pc !== 32'h0 || bif.trap !== 1'b0 || bif.br_cnt !== 4'd0
            || bif.taken_cnt !== 4'd0)
            $display("FAIL rst_hold: pc=%h trap=%b br=%0d tk=%0d, want 0/0/0/0",
                     bif.pc, bif.trap, bif.br_cnt, bif.taken_cnt);
        else npass++;
        rst = 1'b0;
        drv(1, 1, 0, 0, 1, 3'b000, 32'd0, 32'h2, 0, 0, 0);
        tick();
        nchk++;
        if (bif.trap !== 1'b1 || bif.mepc !== 32'h0)
            $display("FAIL trap_enter: trap=%b mepc=%h, want 1/0", bif.trap, bif.mepc);
        else npass++;
        rst = 1'b1;
        drv(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        nchk++;
        if (bif.pc !== 32'h0 || bif.trap !== 1'b0 || bif.mepc !== 32'h0
            || bif.br_cnt !== 4'd0)
            $display("FAIL rst_trap: pc=%h trap=%b mepc=%h br=%0d, want 0/0/0/0",
                     bif.pc, bif.trap, bif.mepc, bif.br_cnt);
        else npass++;
        drv(1, 1, 0, 1, 0, 3'b000, 32'h8, 0, 0, 0, 0);
        nchk++;
        if (bif.taken !== 1'b1)
            $display("FAIL rst_run: taken=%b want 1", bif.taken);
        else npass++;
        tick();
        nchk++;
        if (bif.pc !== 32'h8)
            $display("FAIL rst_run_pc: pc=%h want 8", bif.pc);
        else npass++;
    endtask

    initial begin
        rst = 1'b1;
        bif.trap_ack = 1'b0;
        test_reset();
        test_beq();
        test_cond_table();
        test_jalr_trap();
        test_hold();
        test_illegal_sat();
        test_reset_states();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
